// File: rtl/risc32_consts.sv
// Shared constants for the risc32 core: stall polarity, pipe-stage modes,
// default bubble word and the pipe-stage action encoding.
package risc32_consts;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam int PIPE_MODE_STALL = 0;
    localparam int PIPE_MODE_SKID  = 1;

    localparam logic [63:0] BUBBLE_WORD = 64'h0;
    localparam int          PERF_CNT_W  = 16;

    typedef enum logic [1:0] {
        PIPE_CAPTURE,
        PIPE_BUBBLE,
        PIPE_HOLD,
        PIPE_FLUSH
    } pipe_action_e;

    // Flush wins; a stopped stage with a running successor must emit a bubble.
    function automatic pipe_action_e stall_action(input logic flush,
                                                  input logic stall_self,
                                                  input logic stall_next);
        if (flush)
            return PIPE_FLUSH;
        else if (stall_self == NO_STOP)
            return PIPE_CAPTURE;
        else if (stall_next == NO_STOP)
            return PIPE_BUBBLE;
        else
            return PIPE_HOLD;
    endfunction

endpackage

// File: rtl/risc32_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module risc32_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/risc32_pipe_stage.sv
// Parametrised inter-stage pipeline register: stall-vector mode with bubble
// insertion, or valid/ready mode with a 2-entry skid buffer.
module risc32_pipe_stage
    import risc32_consts::*;
#(
    parameter int                DATA_W  = 64,
    parameter int                STALL_W = 6,
    parameter int                STAGE   = 2,
    parameter int                MODE    = PIPE_MODE_STALL,
    parameter logic [DATA_W-1:0] BUBBLE  = DATA_W'(BUBBLE_WORD),
    parameter int                CNT_W   = PERF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               flush_i,
    input  logic [DATA_W-1:0]  data_i,
    input  logic               valid_i,
    input  logic               next_ds_i,
    output logic               in_ready_o,
    output logic [DATA_W-1:0]  data_o,
    output logic               valid_o,
    output logic               ds_o,
    input  logic               out_ready_i,
    input  logic               cnt_clr_i,
    output logic [CNT_W-1:0]   bubble_cnt_o,
    output logic [CNT_W-1:0]   hold_cnt_o
);

    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              ds_q;
    logic              bubble_inc;
    logic              hold_inc;

    generate
        if (MODE == PIPE_MODE_STALL) begin : g_stall
            pipe_action_e action;
            logic         unused_inputs;

            // NOTE: a combinational block assigns its output on every path,
            // otherwise synthesis infers a latch.
            always_comb begin
                action = stall_action(flush_i, stall_i[STAGE], stall_i[STAGE+1]);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q  <= BUBBLE;
                    valid_q <= 1'b0;
                    ds_q    <= 1'b0;
                end else begin
                    case (action)
                        PIPE_FLUSH: begin
                            data_q  <= BUBBLE;
                            valid_q <= 1'b0;
                            ds_q    <= 1'b0;
                        end
                        // The delay-slot flag survives the bubble.
                        PIPE_BUBBLE: begin
                            data_q  <= BUBBLE;
                            valid_q <= 1'b0;
                            ds_q    <= next_ds_i;
                        end
                        PIPE_CAPTURE: begin
                            data_q  <= data_i;
                            valid_q <= valid_i;
                            ds_q    <= next_ds_i;
                        end
                        default: ;
                    endcase
                end
            end

            assign in_ready_o    = 1'b1;
            assign bubble_inc    = (action == PIPE_BUBBLE);
            assign hold_inc      = (action == PIPE_HOLD);
            assign unused_inputs = ^{stall_i, out_ready_i};
        end else begin : g_skid
            logic [DATA_W-1:0] skid_data;
            logic              skid_ds;
            logic              skid_valid;
            logic              in_ready_q;
            logic              push;
            logic              pop;
            logic              unused_inputs;

            assign push = valid_i & in_ready_q;
            assign pop  = valid_q & out_ready_i;

            always_ff @(posedge clk or posedge rst) begin
                if (rst || flush_i) begin
                    data_q     <= BUBBLE;
                    valid_q    <= 1'b0;
                    ds_q       <= 1'b0;
                    skid_data  <= BUBBLE;
                    skid_ds    <= 1'b0;
                    skid_valid <= 1'b0;
                    in_ready_q <= 1'b1;
                end else if (!valid_q) begin
                    if (push) begin
                        data_q  <= data_i;
                        ds_q    <= next_ds_i;
                        valid_q <= 1'b1;
                    end
                end else if (pop) begin
                    // in_ready_q is low whenever skid is full, so no push here.
                    if (skid_valid) begin
                        data_q     <= skid_data;
                        ds_q       <= skid_ds;
                        skid_valid <= 1'b0;
                        in_ready_q <= 1'b1;
                    end else if (push) begin
                        data_q <= data_i;
                        ds_q   <= next_ds_i;
                    end else begin
                        data_q  <= BUBBLE;
                        ds_q    <= 1'b0;
                        valid_q <= 1'b0;
                    end
                end else if (push) begin
                    skid_data  <= data_i;
                    skid_ds    <= next_ds_i;
                    skid_valid <= 1'b1;
                    in_ready_q <= 1'b0;
                end
            end

            assign in_ready_o    = in_ready_q;
            assign bubble_inc    = !flush_i && !valid_q;
            assign hold_inc      = !flush_i && valid_q && !out_ready_i;
            assign unused_inputs = ^stall_i;
        end
    endgenerate

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign ds_o    = ds_q;

    risc32_sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr_i),
        .inc (bubble_inc),
        .cnt (bubble_cnt_o)
    );

    risc32_sat_counter #(.W(CNT_W)) u_hold_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr_i),
        .inc (hold_inc),
        .cnt (hold_cnt_o)
    );

endmodule

// File: tb/tb_risc32_pipe_stage.sv
// Bench for risc32_pipe_stage: stall mode, skid mode with a scoreboard
// monitor, a 4-bit counter saturation instance and asynchronous reset.
module tb_risc32_pipe_stage;

    localparam logic [63:0] BUB0 = 64'h0000_0000_DEAD_BEEF;
    localparam logic [63:0] BUB1 = 64'hBBBB_BBBB_BBBB_BBBB;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [63:0] data_in;
    logic        valid_in;
    logic        ds_in;
    logic        out_ready;
    logic        cnt_clr;

    logic        u0_in_ready, u0_valid, u0_ds;
    logic [63:0] u0_data;
    logic [15:0] u0_bub_cnt, u0_hold_cnt;
    logic        u1_in_ready, u1_valid, u1_ds;
    logic [63:0] u1_data;
    logic [15:0] u1_bub_cnt, u1_hold_cnt;
    logic        u2_in_ready, u2_valid, u2_ds;
    logic [63:0] u2_data;
    logic [3:0]  u2_bub_cnt, u2_hold_cnt;

    typedef struct {
        logic [63:0] data;
        logic        ds;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    risc32_pipe_stage #(.MODE(0), .BUBBLE(BUB0)) u0 (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .data_i(data_in),
        .valid_i(valid_in), .next_ds_i(ds_in), .in_ready_o(u0_in_ready),
        .data_o(u0_data), .valid_o(u0_valid), .ds_o(u0_ds), .out_ready_i(out_ready),
        .cnt_clr_i(cnt_clr), .bubble_cnt_o(u0_bub_cnt), .hold_cnt_o(u0_hold_cnt)
    );

    risc32_pipe_stage #(.MODE(1), .BUBBLE(BUB1)) u1 (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .data_i(data_in),
        .valid_i(valid_in), .next_ds_i(ds_in), .in_ready_o(u1_in_ready),
        .data_o(u1_data), .valid_o(u1_valid), .ds_o(u1_ds), .out_ready_i(out_ready),
        .cnt_clr_i(cnt_clr), .bubble_cnt_o(u1_bub_cnt), .hold_cnt_o(u1_hold_cnt)
    );

    risc32_pipe_stage #(.MODE(0), .CNT_W(4)) u2 (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .data_i(data_in),
        .valid_i(valid_in), .next_ds_i(ds_in), .in_ready_o(u2_in_ready),
        .data_o(u2_data), .valid_o(u2_valid), .ds_o(u2_ds), .out_ready_i(out_ready),
        .cnt_clr_i(cnt_clr), .bubble_cnt_o(u2_bub_cnt), .hold_cnt_o(u2_hold_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [63:0] d, input logic ds);
        exp_t e;
        e.data = d;
        e.ds   = ds;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: a transfer happens at the next edge when valid & ready.
    always @(negedge clk) begin
        if (!rst && u1_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_pop: unexpected output %h with empty queue", u1_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_data", u1_data, e.data);
                check("sb_ds", 64'(u1_ds), 64'(e.ds));
            end
        end
    end

    initial begin
        rst = 1'b1; stall = '0; flush = 1'b0; data_in = '0; valid_in = 1'b0;
        ds_in = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        #3;
        check("rst_u0_data", u0_data, BUB0);
        check("rst_u0_valid", 64'(u0_valid), 64'd0);
        check("rst_u1_data", u1_data, BUB1);
        check("rst_u1_in_ready", 64'(u1_in_ready), 64'd1);
        check("rst_u0_bub_cnt", 64'(u0_bub_cnt), 64'd0);
        #9;
        rst = 1'b0;

        // Stall mode, STAGE=2.
        stall = 6'b000000; data_in = 64'h1234; valid_in = 1'b1; ds_in = 1'b0;
        step();
        check("cap_data", u0_data, 64'h1234);
        check("cap_valid", 64'(u0_valid), 64'd1);
        check("cap_in_ready", 64'(u0_in_ready), 64'd1);

        stall = 6'b000100; data_in = 64'h5555; ds_in = 1'b1;
        step();
        check("bub_data", u0_data, BUB0);
        check("bub_valid", 64'(u0_valid), 64'd0);
        check("bub_ds", 64'(u0_ds), 64'd1);
        check("bub_cnt", 64'(u0_bub_cnt), 64'd1);
        check("bub_hold_cnt", 64'(u0_hold_cnt), 64'd0);

        stall = 6'b001000; data_in = 64'h7777;
        step();
        check("cap_next_stalled_data", u0_data, 64'h7777);
        check("cap_next_stalled_ds", 64'(u0_ds), 64'd1);

        stall = 6'b000000; data_in = 64'hABCD; ds_in = 1'b0;
        step();
        check("cap2_data", u0_data, 64'hABCD);

        stall = 6'b001100; data_in = 64'h9999; valid_in = 1'b0; ds_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_data", u0_data, 64'hABCD);
            check("hold_valid", 64'(u0_valid), 64'd1);
            check("hold_ds", 64'(u0_ds), 64'd0);
        end
        check("hold_cnt", 64'(u0_hold_cnt), 64'd3);

        flush = 1'b1; stall = 6'b000100;
        step();
        flush = 1'b0;
        check("flush_data", u0_data, BUB0);
        check("flush_valid", 64'(u0_valid), 64'd0);
        check("flush_ds", 64'(u0_ds), 64'd0);
        check("flush_bub_cnt", 64'(u0_bub_cnt), 64'd1);
        check("flush_hold_cnt", 64'(u0_hold_cnt), 64'd3);

        stall = 6'b000000; data_in = 64'h4242; valid_in = 1'b1; ds_in = 1'b0;
        step();
        stall = 6'b001100; cnt_clr = 1'b1; valid_in = 1'b0;
        step();
        cnt_clr = 1'b0;
        check("clr_hold_cnt", 64'(u0_hold_cnt), 64'd0);
        check("clr_bub_cnt", 64'(u0_bub_cnt), 64'd0);
        check("clr_keeps_data", u0_data, 64'h4242);
        check("clr_keeps_valid", 64'(u0_valid), 64'd1);
        stall = 6'b000000;

        // Skid mode: fill main and skid while downstream is stopped.
        flush = 1'b1; cnt_clr = 1'b1;
        step();
        flush = 1'b0; cnt_clr = 1'b0;
        check("skid_flush_valid", 64'(u1_valid), 64'd0);
        check("skid_flush_data", u1_data, BUB1);
        check("skid_flush_in_ready", 64'(u1_in_ready), 64'd1);

        valid_in = 1'b1; data_in = 64'hA; ds_in = 1'b1; push_exp(64'hA, 1'b1);
        step();
        check("skid_a_valid", 64'(u1_valid), 64'd1);
        check("skid_a_data", u1_data, 64'hA);
        check("skid_a_in_ready", 64'(u1_in_ready), 64'd1);

        data_in = 64'hB; ds_in = 1'b0; push_exp(64'hB, 1'b0);
        step();
        check("skid_b_in_ready", 64'(u1_in_ready), 64'd0);
        check("skid_b_main_stable", u1_data, 64'hA);

        data_in = 64'hC;
        step();
        check("skid_c_drop_data", u1_data, 64'hA);
        check("skid_c_ds_stable", 64'(u1_ds), 64'd1);
        check("skid_hold_cnt", 64'(u1_hold_cnt), 64'd2);
        check("skid_bub_cnt", 64'(u1_bub_cnt), 64'd1);

        valid_in = 1'b0; out_ready = 1'b1;
        step();
        check("skid_pop_a_next", u1_data, 64'hB);
        check("skid_pop_a_in_ready", 64'(u1_in_ready), 64'd1);
        step();
        check("skid_pop_b_valid", 64'(u1_valid), 64'd0);
        check("skid_pop_b_data", u1_data, BUB1);
        check("skid_queue_drained", 64'(exp_q.size()), 64'd0);

        // Skid mode: back-to-back stream.
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            valid_in = 1'b1; data_in = 64'(i); ds_in = i[0];
            push_exp(64'(i), i[0]);
            step();
            check("stream_valid", 64'(u1_valid), 64'd1);
            check("stream_data", u1_data, 64'(i));
        end
        valid_in = 1'b0;
        step();
        check("stream_end_valid", 64'(u1_valid), 64'd0);
        check("stream_bub_cnt", 64'(u1_bub_cnt), 64'd1);
        check("stream_queue_drained", 64'(exp_q.size()), 64'd0);

        // Skid mode: flush drops both entries and a same-cycle push.
        out_ready = 1'b0; valid_in = 1'b1; data_in = 64'h1111; ds_in = 1'b1;
        step();
        data_in = 64'h2222;
        step();
        check("skid_full_in_ready", 64'(u1_in_ready), 64'd0);
        flush = 1'b1; data_in = 64'h3333;
        step();
        flush = 1'b0; valid_in = 1'b0;
        check("skid_flush2_valid", 64'(u1_valid), 64'd0);
        check("skid_flush2_data", u1_data, BUB1);
        check("skid_flush2_ds", 64'(u1_ds), 64'd0);
        check("skid_flush2_in_ready", 64'(u1_in_ready), 64'd1);
        step();
        check("skid_flush2_no_push", 64'(u1_valid), 64'd0);

        // 4-bit counter saturation.
        stall = 6'b000100; cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        repeat (14) step();
        check("sat_cnt_14", 64'(u2_bub_cnt), 64'd14);
        repeat (6) step();
        check("sat_cnt_15", 64'(u2_bub_cnt), 64'd15);
        stall = 6'b001100; cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("sat_clr_bub", 64'(u2_bub_cnt), 64'd0);
        check("sat_clr_hold", 64'(u2_hold_cnt), 64'd0);
        step();
        check("sat_hold_1", 64'(u2_hold_cnt), 64'd1);

        // Asynchronous reset mid-stream.
        stall = 6'b000000; valid_in = 1'b1; data_in = 64'hCAFE; ds_in = 1'b1;
        step();
        check("pre_rst_u0_valid", 64'(u0_valid), 64'd1);
        check("pre_rst_u1_valid", 64'(u1_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_u0_data", u0_data, BUB0);
        check("async_rst_u0_valid", 64'(u0_valid), 64'd0);
        check("async_rst_u0_ds", 64'(u0_ds), 64'd0);
        check("async_rst_u0_bub_cnt", 64'(u0_bub_cnt), 64'd0);
        check("async_rst_u1_valid", 64'(u1_valid), 64'd0);
        check("async_rst_u1_data", u1_data, BUB1);
        check("async_rst_u1_in_ready", 64'(u1_in_ready), 64'd1);
        check("async_rst_u2_hold_cnt", 64'(u2_hold_cnt), 64'd0);
        valid_in = 1'b0;
        step();
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/risc32_pipe_stage.md
Name: risc32_pipe_stage

Overview:
- Generic, parametrised inter-stage pipeline register for the risc32 core. It generalises the fixed ID/EX latch.
- Carries a payload bus of configurable width, plus a valid bit and a delay-slot sideband.
- Two modes:
  - MODE=0: the core's stall-vector scheme, with bubble insertion.
  - MODE=1: valid/ready handshake with a 2-entry skid buffer.
- Adds features the old latch lacks: explicit flush and saturating bubble/hold performance counters.
- Instantiated between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 64, payload width in bits.
- STALL_W, 6, width of the core stall vector.
- STAGE, 2, index of this stage's own stall bit. The downstream stage uses bit STAGE+1. Legal range is 0..STALL_W-2.
- MODE, 0, 0 = stall-vector mode, 1 = valid/ready skid mode.
- BUBBLE, 0, DATA_W-bit value driven onto data_o for a bubble, flush or reset.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- stall_i  in  STALL_W  core stall vector. 1 = Stop. Ignored when MODE=1.
- flush_i  in  1  discard stage contents (exception/redirect).
- data_i  in  DATA_W  upstream payload.
- valid_i  in  1  upstream payload valid.
- next_ds_i  in  1  "next instruction is in delay slot" flag from upstream.
- in_ready_o  out  1  upstream may push. Constant 1 when MODE=0.
- data_o  out  DATA_W  registered payload.
- valid_o  out  1  registered valid.
- ds_o  out  1  registered delay-slot flag.
- out_ready_i  in  1  downstream accepts. Ignored when MODE=0.
- cnt_clr_i  in  1  synchronous clear of both counters.
- bubble_cnt_o  out  CNT_W  saturating count of bubble cycles.
- hold_cnt_o  out  CNT_W  saturating count of hold cycles.

Behaviour:
- Reset (asynchronous, rst=1): data_o=BUBBLE, valid_o=0, ds_o=0, skid buffer empty, both counters 0.
  - in_ready_o is 1 immediately after reset is released in MODE=1.
- MODE=0. Evaluated each posedge in this priority order:
  1. flush_i=1: data_o=BUBBLE, valid_o=0, ds_o=0.
  2. Bubble (stall[STAGE]=1 and stall[STAGE+1]=0): data_o=BUBBLE, valid_o=0, ds_o<=next_ds_i. The delay-slot flag is preserved across the bubble.
  3. Capture (stall[STAGE]=0): data_o<=data_i, valid_o<=valid_i, ds_o<=next_ds_i.
  4. Otherwise (both stall bits set): hold all outputs.
  - Latency is 1 cycle.
- MODE=1 (skid buffer). Entries are main (drives the outputs) and skid. The next_ds_i flag travels with its payload.
  - push = valid_i & in_ready_o.
  - pop = valid_o & out_ready_i.
  - in_ready_o is registered and equals !skid_valid.
  - Main empty + push: main<=input; valid_o=1 next cycle.
  - Main full, pop + push: main<=input, no bubble. Sustains 1 transfer per cycle.
  - Main full, no pop, push: skid<=input; in_ready_o=0 next cycle.
  - Pop with skid full: main<=skid, skid empties, in_ready_o=1 next cycle. Push is impossible in this case.
  - Pop with no push and skid empty: valid_o=0, data_o=BUBBLE.
  - While valid_o=1 and out_ready_i=0, data_o/ds_o must not change.
  - flush_i: both entries empty, valid_o=0, data_o=BUBBLE, ds_o=0, in_ready_o=1 next cycle. Any push in the same cycle is dropped.
- Counters:
  - MODE=0: bubble_cnt increments on bubble cycles; hold_cnt increments on hold cycles.
  - MODE=1: bubble_cnt increments when valid_o=0; hold_cnt increments when valid_o=1 and out_ready_i=0.
  - A flush cycle counts as neither.
  - Both counters saturate at all-ones and never wrap.
  - cnt_clr_i takes priority over increment and leaves the pipeline unaffected.
- Reset asserted mid-transfer discards all contents asynchronously. No partial update is permitted.

Decomposition:
- The shared consts package (risc32_consts) gains:
  - Stop/NoStop
  - pipe mode encodings PIPE_MODE_STALL=0 and PIPE_MODE_SKID=1
  - the default BUBBLE word
  - perf counter width
- One sub-module, risc32_sat_counter (width-parametrised, clear/inc, saturating), instantiated twice.
- The two modes are generate branches inside risc32_pipe_stage.

Test Plan:
- MODE=0, STAGE=2: stall=6'b000000, data_i=0x1234, valid_i=1 → next cycle data_o=0x1234, valid_o=1.
- MODE=0: stall=6'b000100, next_ds_i=1 → data_o=BUBBLE, valid_o=0, ds_o=1, bubble_cnt=1.
- MODE=0: stall=6'b001100 for 3 cycles → outputs hold, hold_cnt=3. Then flush_i=1 → valid_o=0, ds_o=0.
- MODE=1: out_ready_i=0, push A then B:
  - in_ready_o=0 after B.
  - Raise out_ready_i: outputs A then B on consecutive cycles.
  - in_ready_o returns to 1 one cycle after A pops.
- MODE=1: continuous push/pop of 0,1,2,…,15 with out_ready_i=1 → 16 outputs on consecutive cycles, bubble_cnt=1 (the fill cycle only).
- CNT_W=4: 20 bubble cycles → bubble_cnt=15 (saturated). Then cnt_clr_i → 0. Also assert rst mid-stream → all outputs at reset values in the same cycle.
